// File: rtl/battle_pkg.sv
// Shared types for the battle grid: cell colours, shot result codes, FSM states.
// Latency: none (types only).
// Backpressure: none (types only).
package battle_pkg;

    typedef enum logic [1:0] {
        CELL_BLUE  = 2'd0,
        CELL_GRAY  = 2'd1,
        CELL_BLACK = 2'd2,
        CELL_RED   = 2'd3
    } cell_state_t;

    typedef enum logic [2:0] {
        RES_NONE    = 3'd0,
        RES_MISS    = 3'd1,
        RES_HIT     = 3'd2,
        RES_SUNK    = 3'd3,
        RES_REPEAT  = 3'd4,
        RES_INVALID = 3'd5
    } res_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_RESP  = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/battle_ship_tracker.sv
// Per-ship health counters and the count of ships still afloat.
// Latency: updates one cycle after inc_en/dec_en; health_q is combinational.
// Backpressure: none; the caller never asserts inc_en and dec_en together.
module battle_ship_tracker #(
    parameter int SW = 3,
    parameter int HW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc_en,
    input  logic [SW-1:0] inc_id,
    input  logic          dec_en,
    input  logic [SW-1:0] query_id,
    output logic [HW-1:0] health_q,
    output logic [SW-1:0] ships_left,
    output logic          all_sunk
);

    localparam int NID = 1 << SW;

    logic [HW-1:0] health [NID];
    logic [NID-1:0] loaded;
    logic           any_loaded;

    assign health_q = health[query_id];
    assign all_sunk = any_loaded && (ships_left == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NID; i++) begin
                health[i] <= '0;
            end
            loaded     <= '0;
            any_loaded <= 1'b0;
            ships_left <= '0;
        end else if (inc_en) begin
            health[inc_id] <= health[inc_id] + 1'b1;
            any_loaded     <= 1'b1;
            // Only the first segment of an id adds a ship to the fleet.
            if (!loaded[inc_id]) begin
                loaded[inc_id] <= 1'b1;
                ships_left     <= ships_left + 1'b1;
            end
        end else if (dec_en) begin
            health[query_id] <= health_q - 1'b1;
            if (health_q == HW'(1)) begin
                ships_left <= ships_left - 1'b1;
            end
        end
    end

endmodule

// File: rtl/battle_grid.sv
// Battleship grid: ship placement, shot evaluation, sunk-ship sweep painting RED.
// Latency: result 2 cycles after shot accept; SUNK 2+ROWS*COLS (full-grid sweep).
// Backpressure: shot_ready only in IDLE with no load pending; load wins collisions.
module battle_grid
    import battle_pkg::*;
#(
    parameter int ROWS     = 10,
    parameter int COLS     = 10,
    parameter int NSHIPS   = 5,
    parameter int MARK_ADJ = 1,
    parameter int RW       = $clog2(ROWS),
    parameter int CW       = $clog2(COLS),
    parameter int SW       = $clog2(NSHIPS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [RW-1:0] load_row,
    input  logic [CW-1:0] load_col,
    input  logic [SW-1:0] load_ship,
    input  logic          shot_valid,
    output logic          shot_ready,
    input  logic [RW-1:0] shot_row,
    input  logic [CW-1:0] shot_col,
    output logic          res_valid,
    output logic [2:0]    res_code,
    output logic [SW-1:0] res_ship,
    input  logic [RW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic [1:0]    rd_state,
    output logic [SW-1:0] ships_left,
    output logic          all_sunk
);

    localparam int NCELL = ROWS * COLS;
    localparam int HW    = $clog2(NCELL + 1);
    localparam int IW    = $clog2(NCELL);

    cell_state_t   cell_st [NCELL];
    logic [SW-1:0] cell_id [NCELL];

    fsm_state_t    state, state_nx;
    logic          locked;
    logic [RW-1:0] sh_row;
    logic [CW-1:0] sh_col;
    logic [SW-1:0] sunk_id;
    logic [IW-1:0] sw_idx;
    logic [RW-1:0] sw_row;
    logic [CW-1:0] sw_col;
    res_code_t     res_code_q;
    logic [SW-1:0] res_ship_q;

    logic          eval_en, sweep_en, resp_en;
    logic          shot_acc, load_ok, load_in_range;
    logic [IW-1:0] load_idx;
    logic          ev_in_range, rd_in_range;
    logic [IW-1:0] ev_idx, rd_idx;
    logic [SW-1:0] ev_id;
    res_code_t     ev_code;
    logic          dec_en;
    logic [HW-1:0] health_q;
    logic          adj_hit, sw_paint;
    int            nr, nc;
    logic [IW-1:0] nb_idx;

    // ---------------- address decode ----------------
    assign load_in_range = (int'(load_row) < ROWS) && (int'(load_col) < COLS);
    assign load_idx      = load_in_range ? IW'(int'(load_row) * COLS + int'(load_col)) : '0;
    assign ev_in_range   = (int'(sh_row) < ROWS) && (int'(sh_col) < COLS);
    assign ev_idx        = ev_in_range ? IW'(int'(sh_row) * COLS + int'(sh_col)) : '0;
    assign rd_in_range   = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
    assign rd_idx        = rd_in_range ? IW'(int'(rd_row) * COLS + int'(rd_col)) : '0;

    assign rd_state = rd_in_range ? cell_st[rd_idx] : CELL_BLUE;

    assign shot_acc = shot_valid && shot_ready;
    assign load_ok  = (state == ST_IDLE) && load_en && !locked && load_in_range
                   && (load_ship != '0) && (int'(load_ship) <= NSHIPS)
                   && (cell_id[load_idx] == '0);

    // ---------------- shot classification ----------------
    assign ev_id = cell_id[ev_idx];

    always_comb begin
        ev_code = RES_MISS;
        if (!ev_in_range) begin
            ev_code = RES_INVALID;
        end else if (cell_st[ev_idx] != CELL_BLUE) begin
            ev_code = RES_REPEAT;
        end else if (ev_id == '0) begin
            ev_code = RES_MISS;
        end else if (health_q > HW'(1)) begin
            ev_code = RES_HIT;
        end else begin
            ev_code = RES_SUNK;
        end
    end

    assign dec_en = eval_en && ((ev_code == RES_HIT) || (ev_code == RES_SUNK));

    // ---------------- sweep neighbourhood (edges clipped) ----------------
    always_comb begin
        adj_hit = 1'b0;
        nr      = 0;
        nc      = 0;
        nb_idx  = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr = int'(sw_row) + dr;
                nc = int'(sw_col) + dc;
                if (!(dr == 0 && dc == 0) && nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
                    nb_idx = IW'(nr * COLS + nc);
                    if (cell_id[nb_idx] == sunk_id) begin
                        adj_hit = 1'b1;
                    end
                end
            end
        end
    end

    assign sw_paint = (cell_id[sw_idx] == sunk_id)
                   || ((MARK_ADJ != 0) && (cell_st[sw_idx] == CELL_BLUE)
                       && (cell_id[sw_idx] == '0) && adj_hit);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (shot_acc) state_nx = ST_EVAL;
            ST_EVAL:  state_nx = (ev_code == RES_SUNK) ? ST_SWEEP : ST_RESP;
            ST_SWEEP: if (sw_idx == IW'(NCELL - 1)) state_nx = ST_RESP;
            ST_RESP:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        shot_ready = (state == ST_IDLE) && !load_en;
        eval_en    = (state == ST_EVAL);
        sweep_en   = (state == ST_SWEEP);
        resp_en    = (state == ST_RESP);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCELL; i++) begin
                cell_st[i] <= CELL_BLUE;
                cell_id[i] <= '0;
            end
            locked     <= 1'b0;
            sh_row     <= '0;
            sh_col     <= '0;
            sunk_id    <= '0;
            sw_idx     <= '0;
            sw_row     <= '0;
            sw_col     <= '0;
            res_code_q <= RES_NONE;
            res_ship_q <= '0;
            res_valid  <= 1'b0;
            res_code   <= '0;
            res_ship   <= '0;
        end else begin
            if (load_ok) begin
                cell_id[load_idx] <= load_ship;
            end
            if (shot_acc) begin
                locked <= 1'b1;
                sh_row <= shot_row;
                sh_col <= shot_col;
            end
            if (eval_en) begin
                res_code_q <= ev_code;
                res_ship_q <= dec_en ? ev_id : '0;
                if (ev_code == RES_MISS) begin
                    cell_st[ev_idx] <= CELL_GRAY;
                end else if (dec_en) begin
                    cell_st[ev_idx] <= CELL_BLACK;
                end
                sunk_id <= ev_id;
                sw_idx  <= '0;
                sw_row  <= '0;
                sw_col  <= '0;
            end
            if (sweep_en) begin
                if (sw_paint) begin
                    cell_st[sw_idx] <= CELL_RED;
                end
                sw_idx <= sw_idx + 1'b1;
                if (int'(sw_col) == COLS - 1) begin
                    sw_col <= '0;
                    sw_row <= sw_row + 1'b1;
                end else begin
                    sw_col <= sw_col + 1'b1;
                end
            end
            res_valid <= resp_en;
            res_code  <= resp_en ? res_code_q : 3'd0;
            res_ship  <= resp_en ? res_ship_q : '0;
        end
    end

    battle_ship_tracker #(
        .SW (SW),
        .HW (HW)
    ) u_tracker (
        .clk        (clk),
        .reset      (reset),
        .inc_en     (load_ok),
        .inc_id     (load_ship),
        .dec_en     (dec_en),
        .query_id   (ev_id),
        .health_q   (health_q),
        .ships_left (ships_left),
        .all_sunk   (all_sunk)
    );

endmodule

// File: doc/battle_grid.md
BATTLE_GRID -- requirements
Module: battle_grid

Interface
REQ-001 SHALL have parameter ROWS, default 10, number of grid rows (2..16).
REQ-002 SHALL have parameter COLS, default 10, number of grid columns (2..16).
REQ-003 SHALL have parameter NSHIPS, default 5, maximum ship ids (1..15); id 0 means water.
REQ-004 SHALL have parameter MARK_ADJ, default 1; 1 turns water cells 8-adjacent to a sunk ship RED.
REQ-005 SHALL use widths RW=$clog2(ROWS), CW=$clog2(COLS), SW=$clog2(NSHIPS+1).
REQ-006 SHALL have ports:
 clk  in  1  clock, rising edge;
 reset  in  1  asynchronous, active-high;
 load_en  in  1  place ship segment this cycle;
 load_row/load_col  in  RW/CW  placement cell;
 load_ship  in  SW  ship id 1..NSHIPS;
 shot_valid  in  1  shot request;
 shot_ready  out  1  shot accepted when valid&ready;
 shot_row/shot_col  in  RW/CW  target cell;
 res_valid  out  1  one-cycle result pulse;
 res_code  out  3  1 MISS, 2 HIT, 3 SUNK, 4 REPEAT, 5 INVALID;
 res_ship  out  SW  ship id for HIT/SUNK, else 0;
 rd_row/rd_col  in  RW/CW  display read address;
 rd_state  out  2  combinational cell state: 0 BLUE, 1 GRAY, 2 BLACK, 3 RED;
 ships_left  out  SW  ships loaded and not sunk;
 all_sunk  out  1  ships_left==0 and at least one ship loaded.

Function
REQ-007 SHALL hold per cell a 2-bit state and an SW-bit ship id, plus per-id health counter (width $clog2(ROWS*COLS+1)).
REQ-008 SHALL run FSM IDLE -> EVAL -> (RESP | SWEEP -> RESP) -> IDLE.
REQ-009 Load SHALL be honoured only in IDLE before the first accepted shot; in-range cell with id 0 takes load_ship and health[load_ship]+1; occupied, out-of-range or id 0/>NSHIPS loads ignored.
REQ-010 A new id's first load SHALL increment ships_left.
REQ-011 shot_ready SHALL be 1 only in IDLE with load_en=0 (load wins on collision).
REQ-012 EVAL (cycle after accept) SHALL classify: out-of-range -> INVALID; cell not BLUE -> REPEAT; id 0 -> GRAY, MISS; id k with health>1 -> BLACK, HIT, health-1; health==1 -> BLACK, health 0, ships_left-1, go SWEEP.
REQ-013 SWEEP SHALL visit cell index 0..ROWS*COLS-1 one per cycle, setting RED every cell with id k and, if MARK_ADJ, every BLUE id-0 cell with an 8-neighbour of id k (edges clipped, no wrap).
REQ-014 RESP SHALL drive res_valid=1 for exactly one cycle with code/id; non-sunk latency 2 cycles from accept edge, SUNK latency 2+ROWS*COLS.
REQ-015 INVALID and REPEAT SHALL change no state or counters.
REQ-016 Shots after all_sunk SHALL be processed normally (REPEAT/MISS).
REQ-017 rd_state SHALL return BLUE for out-of-range read address.

Reset
REQ-018 Reset SHALL force all cells BLUE/id 0, health 0, ships_left 0, FSM IDLE, res_valid 0, res_code 0, res_ship 0, load-lock cleared, including mid-SWEEP.

Structure
REQ-019 Package battle_pkg SHALL hold cell-state, result-code and FSM-state enums.
REQ-020 Sub-module battle_ship_tracker SHALL own health counters and ships_left.

Verification (ROWS=COLS=4, NSHIPS=2, MARK_ADJ=1)
REQ-021 Load ship1 at (0,0),(0,1); shot (0,0) -> HIT id1, rd_state(0,0)=2, res_valid 2 cycles after accept.
REQ-022 Then shot (0,1) -> SUNK id1 after 18 cycles; (0,0),(0,1),(0,2),(1,0..2) read 3; ships_left 0, all_sunk 1.
REQ-023 Shot (3,3) water -> MISS, state 1; repeat (3,3) -> REPEAT, no change.
REQ-024 Shot row 5 (ROWS=4 with RW=2 unreachable; use ROWS=5 build, row 6 N/A) -> use ROWS=3: shot (3,0) -> INVALID.
REQ-025 load_en and shot_valid same cycle -> shot_ready 0, load applied; reset asserted mid-SWEEP -> all rd_state 0, res_valid never pulses.
